gcd_datapath: RTL and testbench

Datapath half of the GCD FSMD. It holds the x/y operand registers, the shared subtractor, the comparators and the result register. It consumes the control word (ldx, ldy, ldd, Sx, Sy, Ss) from the GCD control unit and returns the status flags (xeqy, xgty) to it. It also publishes the result with a sticky valid flag and a subtract-iteration count for performance monitoring.

---
 rtl/gcd_pkg.sv | 11 +
 rtl/gcd_iter_counter.sv | 43 ++++
 rtl/gcd_datapath.sv | 92 +++++++++
 tb/tb_gcd_datapath.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared constants for the GCD FSMD: default width and the control-word encodings
// used by both the datapath and the control unit.
package gcd_pkg;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic SUB_XY = 1'b0;
    localparam logic SUB_YX = 1'b1;

    localparam logic SEL_IN  = 1'b0;
    localparam logic SEL_SUB = 1'b1;
endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating subtract-step counter with a capture register that publishes the
// count of the last completed GCD.
module gcd_iter_counter #(
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic              cap_i,
    output logic [ITER_W-1:0] count_o,
    output logic [ITER_W-1:0] cap_o
);
    logic [ITER_W-1:0] count_q, count_d;
    logic [ITER_W-1:0] cap_q, cap_d;

    always_comb begin
        count_d = count_q;
        cap_d   = cap_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {ITER_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
        // Capture sees the count before this cycle's update.
        if (cap_i) begin
            cap_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            cap_q   <= '0;
        end else begin
            count_q <= count_d;
            cap_q   <= cap_d;
        end
    end

    assign count_o = count_q;
    assign cap_o   = cap_q;
endmodule

// File: rtl/gcd_datapath.sv
// Datapath half of the GCD FSMD: operand registers, shared subtractor, comparators,
// result register with sticky valid, and the subtract-step counter.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go_i,
    input  logic [WIDTH-1:0]  x_i,
    input  logic [WIDTH-1:0]  y_i,
    input  logic              ldx,
    input  logic              ldy,
    input  logic              ldd,
    input  logic              Sx,
    input  logic              Sy,
    input  logic              Ss,
    output logic              xeqy,
    output logic              xgty,
    output logic [WIDTH-1:0]  d_o,
    output logic              d_valid_o,
    output logic [ITER_W-1:0] iter_o
);
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              d_valid_q, d_valid_d;
    logic [WIDTH-1:0]  sub;
    logic              load_cycle;
    logic              sub_cycle;
    logic [ITER_W-1:0] count_unused;

    assign sub = (Ss == SUB_YX) ? (y_q - x_q) : (x_q - y_q);

    assign load_cycle = ldx & ldy & ~Sx & ~Sy;
    assign sub_cycle  = (ldx & Sx) | (ldy & Sy);

    // A zero operand counts as "equal" so the control unit never loops on y - 0.
    assign xeqy = (x_q == y_q) || (x_q == '0) || (y_q == '0);
    assign xgty = (x_q > y_q);

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        d_d       = d_q;
        d_valid_d = d_valid_q;
        if (ldx) begin
            x_d = (Sx == SEL_SUB) ? sub : x_i;
        end
        if (ldy) begin
            y_d = (Sy == SEL_SUB) ? sub : y_i;
        end
        // ldd takes priority over go_i so a result landing with a new start stays valid.
        if (ldd) begin
            d_d       = (x_q == '0) ? y_q : x_q;
            d_valid_d = 1'b1;
        end else if (go_i) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
        end
    end

    gcd_iter_counter #(
        .ITER_W (ITER_W)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (load_cycle),
        .inc_i   (sub_cycle),
        .cap_i   (ldd),
        .count_o (count_unused),
        .cap_o   (iter_o)
    );

    assign d_o       = d_q;
    assign d_valid_o = d_valid_q;
endmodule

// File: tb/tb_gcd_datapath.sv
// Bench for gcd_datapath: acts as a simple control unit and checks results
// against a Euclid-by-division reference model.
module tb_gcd_datapath;
    localparam int WIDTH   = 8;
    localparam int ITER_W  = 4;
    localparam int ITER_MAX = (1 << ITER_W) - 1;
    localparam int BUDGET  = 600;

    logic              clk = 1'b0;
    logic              reset;
    logic              go_i, ldx, ldy, ldd, Sx, Sy, Ss;
    logic [WIDTH-1:0]  x_i, y_i;
    logic              xeqy, xgty;
    logic [WIDTH-1:0]  d_o;
    logic              d_valid_o;
    logic [ITER_W-1:0] iter_o;

    int errors = 0;
    int checks = 0;

    gcd_datapath #(.WIDTH(WIDTH), .ITER_W(ITER_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .go_i      (go_i),
        .x_i       (x_i),
        .y_i       (y_i),
        .ldx       (ldx),
        .ldy       (ldy),
        .ldd       (ldd),
        .Sx        (Sx),
        .Sy        (Sy),
        .Ss        (Ss),
        .xeqy      (xeqy),
        .xgty      (xgty),
        .d_o       (d_o),
        .d_valid_o (d_valid_o),
        .iter_o    (iter_o)
    );

    always #5 clk = ~clk;

    // Reference: gcd via Euclid's division; subtract steps = sum of quotients - 1.
    function automatic void model(input int a, input int b, output int d, output int it);
        int p, q, r, s;
        if (a == 0 || b == 0) begin
            d  = (a == 0) ? b : a;
            it = 0;
            return;
        end
        p = a; q = b; s = 0;
        while (q != 0) begin
            s += p / q;
            r = p % q;
            p = q;
            q = r;
        end
        d  = p;
        it = (s - 1 > ITER_MAX) ? ITER_MAX : s - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        go_i = 0; ldx = 0; ldy = 0; ldd = 0; Sx = 0; Sy = 0; Ss = 0;
    endtask

    // Controller emulation: load, subtract until xeqy, then ldd.
    task automatic run_gcd(input int a, input int b, output bit done,
                           output logic eq0, output logic gt0, output logic v0);
        int n;
        x_i = WIDTH'(a); y_i = WIDTH'(b);
        idle_ctrl();
        go_i = 1; ldx = 1; ldy = 1;
        tick();
        idle_ctrl();
        eq0 = xeqy; gt0 = xgty; v0 = d_valid_o;
        done = 0;
        for (n = 0; n < BUDGET && !done; n++) begin
            if (xeqy) begin
                ldd = 1;
                tick();
                idle_ctrl();
                done = 1;
            end else if (xgty) begin
                ldx = 1; Sx = 1; Ss = 0;
                tick();
                idle_ctrl();
            end else begin
                ldy = 1; Sy = 1; Ss = 1;
                tick();
                idle_ctrl();
            end
        end
    endtask

    task automatic check_run(input string name, input int a, input int b);
        bit done; logic eq0, gt0, v0;
        int d_exp, it_exp;
        model(a, b, d_exp, it_exp);
        run_gcd(a, b, done, eq0, gt0, v0);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL %s timeout: no xeqy within %0d cycles", name, BUDGET);
        end
        checks++;
        if (eq0 !== ((a == b) || a == 0 || b == 0)) begin
            errors++; $display("FAIL %s xeqy after load: got %b want %b", name, eq0, ((a == b) || a == 0 || b == 0));
        end
        checks++;
        if (gt0 !== (a > b)) begin
            errors++; $display("FAIL %s xgty after load: got %b want %b", name, gt0, (a > b));
        end
        checks++;
        if (v0 !== 1'b0) begin
            errors++; $display("FAIL %s valid after go: got %b want 0", name, v0);
        end
        checks++;
        if (d_o !== WIDTH'(d_exp) || d_valid_o !== 1'b1 || iter_o !== ITER_W'(it_exp)) begin
            errors++;
            $display("FAIL %s result: got d=%0d v=%b it=%0d want d=%0d v=1 it=%0d",
                     name, d_o, d_valid_o, iter_o, d_exp, it_exp);
        end
        $display("run %s: x=%0d y=%0d -> d=%0d it=%0d", name, a, b, d_o, iter_o);
    endtask

    task automatic test_reset();
        reset = 1; idle_ctrl(); x_i = 8'hA5; y_i = 8'h5A;
        tick(); tick();
        checks++;
        if (d_o !== 0 || d_valid_o !== 0 || iter_o !== 0 || xeqy !== 1 || xgty !== 0) begin
            errors++;
            $display("FAIL reset: got d=%0d v=%b it=%0d eq=%b gt=%b want 0 0 0 1 0",
                     d_o, d_valid_o, iter_o, xeqy, xgty);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_directed();
        check_run("12_8", 12, 8);
        check_run("7_7", 7, 7);
        check_run("0_9", 0, 9);
        check_run("0_0", 0, 0);
        check_run("9_0", 9, 0);
        check_run("255_1_sat", 255, 1);
        check_run("1_255_sat", 1, 255);
    endtask

    task automatic test_hold();
        check_run("hold_pre", 12, 8);
        for (int i = 0; i < 3; i++) begin
            x_i = 8'(30 + i); y_i = 8'(7 * i + 1);
            ldx = 1; ldy = 1;
            tick();
            idle_ctrl();
        end
        checks++;
        if (d_o !== 8'd4 || d_valid_o !== 1'b1 || iter_o !== 4'd2) begin
            errors++;
            $display("FAIL hold: got d=%0d v=%b it=%0d want d=4 v=1 it=2", d_o, d_valid_o, iter_o);
        end
        go_i = 1; ldd = 1;
        tick();
        idle_ctrl();
        checks++;
        if (d_valid_o !== 1'b1) begin
            errors++; $display("FAIL ldd_over_go: got v=%b want 1", d_valid_o);
        end
        go_i = 1;
        tick();
        idle_ctrl();
        checks++;
        if (d_valid_o !== 1'b0) begin
            errors++; $display("FAIL go_clears: got v=%b want 0", d_valid_o);
        end
        $display("hold: d=%0d it=%0d v=%b", d_o, iter_o, d_valid_o);
    endtask

    task automatic test_async_reset();
        check_run("pre_rst", 20, 5);
        x_i = 8'd48; y_i = 8'd18;
        go_i = 1; ldx = 1; ldy = 1; tick(); idle_ctrl();
        ldx = 1; Sx = 1; tick(); idle_ctrl();
        ldx = 1; Sx = 1; tick(); idle_ctrl();
        #2 reset = 1;
        #1;
        checks++;
        if (d_o !== 0 || d_valid_o !== 0 || iter_o !== 0 || xeqy !== 1 || xgty !== 0) begin
            errors++;
            $display("FAIL async_reset: got d=%0d v=%b it=%0d eq=%b gt=%b want 0 0 0 1 0",
                     d_o, d_valid_o, iter_o, xeqy, xgty);
        end
        tick();
        reset = 0;
        tick();
        check_run("48_18_after_rst", 48, 18);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int a, b;
            a = $urandom_range(0, 255);
            b = (i % 4 == 0) ? a : $urandom_range(0, 255);
            check_run($sformatf("rand%0d", i), a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
